sha_msg_sched: RTL and testbench
================================

Name: sha_msg_sched

Overview:
Parametrised message-schedule engine for the hash cores. It accepts one 512-bit padded block over a valid/ready handshake and emits the expanded schedule words W[0..N-1], one per accepted cycle, under consumer back-pressure.
- Mode is selectable per block: SHA-1 (80 words, rotl1 XOR recurrence) or SHA-256 (64 words, sigma-add recurrence).
- It replaces the fixed SHA-1-only shift-register schedule and sits between the block buffer and the round datapath.

Parameters:
SHA2_EN, 1, 1 = SHA-256 datapath instantiated; 0 = mode input ignored and every block runs SHA-1.
IDX_W, 7, width of the w_idx round-index output. Must be at least 7.

Ports:
clk        input   1      rising-edge clock
reset_n    input   1      asynchronous, active-low reset
mode       input   1      0 = SHA-1, 1 = SHA-256; sampled only on block acceptance
abort      input   1      synchronous cancel of the current block
blk_valid  input   1      blk_data holds a block
blk_ready  output  1      engine can accept a block
blk_data   input   512    W0 = [511:480] ... W15 = [31:0]
w_valid    output  1      w_data/w_idx/w_last are valid
w_ready    input   1      consumer accepts the current word
w_data     output  32     schedule word W[t]
w_idx      output  IDX_W  t
w_last     output  1      t is the final round (79 for SHA-1, 63 for SHA-256)
busy       output  1      block in progress (state RUN)

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE, blk_ready=1, w_valid=0, w_data=0, w_idx=0, w_last=0, busy=0, window cleared.
- Internal state:
  - 16-entry 32-bit window win[0..15] holding W[t..t+15].
  - Round counter t.
  - Latched mode bit m.
  - FSM with states IDLE and RUN.
- IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid & blk_ready: load win[i] = blk_data word i, t=0, m = (SHA2_EN ? mode : 0), go to RUN.
  - The first word is valid on the next cycle (acceptance-to-W0 latency is 1).
- RUN:
  - blk_ready=0, w_valid=1, busy=1.
  - w_data = win[0], w_idx = t, w_last = (t == LAST(m)).
  - All outputs are registered or decoded from registers only, with no combinational path from w_ready.
- Word advance, on w_valid & w_ready:
  - Shift win[i] <= win[i+1] for i = 0..14.
  - win[15] <= Wnew; t <= t+1.
- Wnew for SHA-1: rotl1(win[13] ^ win[8] ^ win[2] ^ win[0]).
- Wnew for SHA-256: sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32.
  - sigma0(x) = ror7 ^ ror18 ^ shr3.
  - sigma1(x) = ror17 ^ ror19 ^ shr10.
- Stall: while w_valid & !w_ready, all outputs and state hold.
- Last word: handshake with w_last=1 returns to IDLE.
  - w_valid=0 and blk_ready=1 on the following cycle.
  - No overlap between blocks: minimum gap is one cycle.
- abort in RUN: next cycle is IDLE with w_valid=0 and t=0. Any handshake in that same cycle is discarded. abort in IDLE has no effect.
- Mode input: changes during RUN are ignored, because only the latched m is used.
- Reset mid-block: immediately returns to the reset values above. A partial schedule is never resumed.
- Wnew is computed combinationally from the window. Timing closure is met at 32 bits without pipelining.

Decomposition:
- Package sha_sched_pkg holds:
  - Mode encodings MODE_SHA1=0 and MODE_SHA256=1.
  - Constants ROUNDS_SHA1=80 and ROUNDS_SHA256=64, plus the derived LAST values.
  - State enum for IDLE and RUN.
- One sub-module, sha_sched_next: purely combinational. Takes win[0], win[1], win[2], win[8], win[9], win[13], win[14] and m, and returns Wnew. It allows equivalence-checking the recurrences in isolation.

Test Plan:
- SHA-1 "abc": blk_data = 0x61626380, 13 zero words, 0x00000000, 0x00000018; w_ready=1; mode=0.
  - W0=0x61626380, W15=0x00000018, W16=0xC2C4C700.
  - w_last asserts at w_idx=79, then blk_ready=1 one cycle later.
- SHA-256 "abc": same block, mode=1.
  - W16=0x61626380, W17=0x000F0000.
  - w_last asserts at w_idx=63.
- Back-pressure: toggle w_ready pseudo-randomly during a SHA-256 block.
  - The word sequence matches the ungated run exactly.
  - w_data and w_idx are stable whenever w_ready=0.
- Abort: assert abort at w_idx=20.
  - Next cycle w_valid=0 and blk_ready=1.
  - The next block restarts at w_idx=0 with W0 of the new block.
- Reset mid-block: drop reset_n asynchronously at w_idx=5. All outputs go to their reset values immediately.
- SHA2_EN=0 build: mode=1 on acceptance runs SHA-1, with 80 words and W16=0xC2C4C700 for the "abc" block.

Source files
------------

// File: rtl/sha_msg_sched_pkg.sv
// sha_sched_pkg: shared encodings, round counts and FSM state type for the message scheduler.
// No ports. Provides MODE_*, ROUNDS_*, LAST_* and state_t.
package sha_sched_pkg;
    localparam logic MODE_SHA1   = 1'b0;
    localparam logic MODE_SHA256 = 1'b1;
    localparam int ROUNDS_SHA1   = 80;
    localparam int ROUNDS_SHA256 = 64;
    localparam int LAST_SHA1     = ROUNDS_SHA1 - 1;
    localparam int LAST_SHA256   = ROUNDS_SHA256 - 1;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sha_msg_sched_if.sv
// sha_msg_sched_if: block-in / word-out handshake bundle of the message scheduler.
// blk_valid/blk_ready/blk_data : 512-bit block input, W0 in [511:480]
// w_valid/w_ready/w_data/w_idx/w_last : schedule word output stream
// modport master = scheduler side, modport slave = producer/consumer side.
interface sha_msg_sched_if #(parameter int IDX_W = 7);
    logic             blk_valid;
    logic             blk_ready;
    logic [511:0]     blk_data;
    logic             w_valid;
    logic             w_ready;
    logic [31:0]      w_data;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    modport master (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_data, w_idx, w_last
    );
    modport slave (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_data, w_idx, w_last
    );
endinterface

// File: rtl/sha_msg_sched_next.sv
// sha_sched_next: combinational next schedule word from the 16-word window.
// w0..w14 : window taps win[0], win[1], win[2], win[8], win[9], win[13], win[14]
// m       : latched mode (0 = SHA-1, 1 = SHA-256)
// wnew    : W[t+16]
module sha_sched_next
    import sha_sched_pkg::*;
#(
    parameter bit SHA2_EN = 1'b1
) (
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [31:0] w8,
    input  logic [31:0] w9,
    input  logic [31:0] w13,
    input  logic [31:0] w14,
    input  logic        m,
    output logic [31:0] wnew
);
    logic [31:0] x1, sha1_w, s0, s1, sha2_w;
    assign x1     = w13 ^ w8 ^ w2 ^ w0;
    assign sha1_w = {x1[30:0], x1[31]};
    assign s0     = {w1[6:0], w1[31:7]} ^ {w1[17:0], w1[31:18]} ^ (w1 >> 3);
    assign s1     = {w14[16:0], w14[31:17]} ^ {w14[18:0], w14[31:19]} ^ (w14 >> 10);
    assign sha2_w = s1 + w9 + s0 + w0;
    // With SHA2_EN=0 the SHA-256 adder tree is constant-folded away.
    assign wnew   = (SHA2_EN && m == MODE_SHA256) ? sha2_w : sha1_w;
endmodule

// File: rtl/sha_msg_sched.sv
// sha_msg_sched: expands one 512-bit block into the SHA-1 or SHA-256 message schedule.
// clk, reset_n (async, active-low), mode (sampled on acceptance), abort (sync cancel),
// busy (block in progress), bus (master modport: block input and word output stream).
module sha_msg_sched
    import sha_sched_pkg::*;
#(
    parameter bit SHA2_EN = 1'b1,
    parameter int IDX_W   = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              abort,
    output logic              busy,
    sha_msg_sched_if.master   bus
);
    if (IDX_W < 7) begin : g_idx_chk
        $error("IDX_W must be at least 7");
    end

    state_t           state, state_d;
    logic [31:0]      win [16];
    logic [IDX_W-1:0] t, last_t;
    logic             m, load, adv;
    logic [31:0]      wnew;

    assign load   = state == IDLE && bus.blk_valid;
    assign adv    = state == RUN && bus.w_ready;
    assign last_t = (m == MODE_SHA256) ? IDX_W'(LAST_SHA256) : IDX_W'(LAST_SHA1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = load ? RUN : IDLE;
        else if (abort || (adv && t == last_t))
            state_d = IDLE;
    end

    sha_sched_next #(.SHA2_EN(SHA2_EN)) u_next (
        .w0(win[0]), .w1(win[1]), .w2(win[2]), .w8(win[8]), .w9(win[9]),
        .w13(win[13]), .w14(win[14]), .m(m), .wnew(wnew)
    );

    // Abort takes priority over a same-cycle handshake so that word is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            t <= '0;
            m <= MODE_SHA1;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= bus.blk_data[511-32*i -: 32];
            t <= '0;
            m <= SHA2_EN ? mode : MODE_SHA1;
        end else if (state == RUN && abort) begin
            t <= '0;
        end else if (adv) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= wnew;
            t <= (t == last_t) ? '0 : t + 1'b1;
        end
    end

    assign bus.blk_ready = state == IDLE;
    assign bus.w_valid   = state == RUN;
    assign bus.w_data    = win[0];
    assign bus.w_idx     = t;
    assign bus.w_last    = state == RUN && t == last_t;
    assign busy          = state == RUN;
endmodule

// File: tb/tb_sha_msg_sched.sv
// tb_sha_msg_sched: directed self-checking bench for sha_msg_sched (SHA2_EN=1 and SHA2_EN=0 builds).
module tb_sha_msg_sched;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mode = 1'b0, abort = 1'b0, busy;
    logic mode2 = 1'b0, abort2 = 1'b0, busy2;
    int tests = 0, fails = 0;
    logic [31:0] ref_w [80];
    logic [31:0] cap [80];
    logic [511:0] abc_blk, blk2;

    sha_msg_sched_if #(.IDX_W(7)) bus ();
    sha_msg_sched_if #(.IDX_W(7)) bus2 ();

    sha_msg_sched #(.SHA2_EN(1'b1), .IDX_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .abort(abort), .busy(busy), .bus(bus.master)
    );
    sha_msg_sched #(.SHA2_EN(1'b0), .IDX_W(7)) dut2 (
        .clk(clk), .reset_n(reset_n), .mode(mode2), .abort(abort2), .busy(busy2), .bus(bus2.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sg0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sg1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_ref(input logic [511:0] blk, input bit sha2);
        for (int i = 0; i < 16; i++) ref_w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++)
            ref_w[i] = sha2 ? sg1(ref_w[i-2]) + ref_w[i-7] + sg0(ref_w[i-15]) + ref_w[i-16]
                            : ror(ref_w[i-3] ^ ref_w[i-8] ^ ref_w[i-14] ^ ref_w[i-16], 31);
    endtask

    task automatic load(input logic [511:0] blk, input logic md);
        @(negedge clk);
        tests++;
        if (bus.blk_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_ready: blk_ready=%b required 1", bus.blk_ready);
        end
        bus.blk_valid = 1'b1;
        bus.blk_data = blk;
        mode = md;
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
        bus.blk_data = '1;
    endtask

    task automatic stream(input int rounds, input bit gate, input bit wiggle, input int stop_at);
        int cnt = 0;
        int guard = 0;
        bit hs;
        while (cnt < rounds && guard < 1000) begin
            @(negedge clk);
            guard++;
            tests++;
            if (bus.w_valid !== 1'b1 || bus.w_idx !== 7'(cnt) || bus.w_data !== ref_w[cnt] ||
                bus.w_last !== (cnt == rounds - 1) || busy !== 1'b1) begin
                fails++;
                $display("FAIL word t=%0d: valid=%b idx=%0d data=%h last=%b busy=%b, required valid=1 idx=%0d data=%h last=%b busy=1",
                         cnt, bus.w_valid, bus.w_idx, bus.w_data, bus.w_last, busy,
                         cnt, ref_w[cnt], cnt == rounds - 1);
            end
            cap[cnt] = bus.w_data;
            if (cnt == stop_at) return;
            if (wiggle) mode = 1'($urandom_range(0, 1));
            hs = gate ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.w_ready = hs;
            if (hs) cnt++;
        end
        if (cnt < rounds) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: words=%0d required %0d", cnt, rounds);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        tests++;
        if (bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1 || busy !== 1'b0 || bus.w_last !== 1'b0) begin
            fails++;
            $display("FAIL %s: valid=%b ready=%b busy=%b last=%b, required 0 1 0 0",
                     tag, bus.w_valid, bus.blk_ready, busy, bus.w_last);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 ||
            bus.w_idx !== 7'd0 || bus.w_last !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: ready=%b valid=%b data=%h idx=%0d last=%b busy=%b, required 1 0 00000000 0 0 0",
                     tag, bus.blk_ready, bus.w_valid, bus.w_data, bus.w_idx, bus.w_last, busy);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset_release");
    endtask

    task automatic test_sha1_abc;
        build_ref(abc_blk, 1'b0);
        load(abc_blk, 1'b0);
        stream(80, 1'b0, 1'b0, -1);
        tests++;
        if (cap[0] !== 32'h61626380 || cap[15] !== 32'h00000018 || cap[16] !== 32'hC2C4C700) begin
            fails++;
            $display("FAIL sha1_abc_words: W0=%h W15=%h W16=%h required 61626380 00000018 c2c4c700",
                     cap[0], cap[15], cap[16]);
        end
        check_idle("sha1_end");
    endtask

    task automatic test_sha256_abc;
        build_ref(abc_blk, 1'b1);
        load(abc_blk, 1'b1);
        stream(64, 1'b0, 1'b0, -1);
        tests++;
        if (cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000) begin
            fails++;
            $display("FAIL sha256_abc_words: W16=%h W17=%h required 61626380 000f0000", cap[16], cap[17]);
        end
        check_idle("sha256_end");
    endtask

    task automatic test_back_pressure;
        build_ref(blk2, 1'b1);
        load(blk2, 1'b1);
        stream(64, 1'b1, 1'b1, -1);
        bus.w_ready = 1'b1;
        check_idle("backpressure_end");
    endtask

    task automatic test_abort;
        build_ref(blk2, 1'b0);
        load(blk2, 1'b0);
        stream(80, 1'b0, 1'b0, 20);
        abort = 1'b1;
        bus.w_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_idle("abort_idle");
        tests++;
        if (bus.w_idx !== 7'd0) begin
            fails++;
            $display("FAIL abort_idx: w_idx=%0d required 0", bus.w_idx);
        end
        build_ref(abc_blk, 1'b1);
        load(abc_blk, 1'b1);
        stream(64, 1'b0, 1'b0, -1);
        check_idle("after_abort_end");
    endtask

    task automatic test_reset_mid;
        build_ref(abc_blk, 1'b0);
        load(abc_blk, 1'b0);
        stream(80, 1'b0, 1'b0, 5);
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_mid_release");
    endtask

    task automatic test_sha2_disabled;
        int cnt = 0;
        int guard = 0;
        build_ref(abc_blk, 1'b0);
        @(negedge clk);
        bus2.blk_valid = 1'b1;
        bus2.blk_data = abc_blk;
        mode2 = 1'b1;
        @(posedge clk);
        #1;
        bus2.blk_valid = 1'b0;
        while (cnt < 80 && guard < 200) begin
            @(negedge clk);
            guard++;
            tests++;
            if (bus2.w_valid !== 1'b1 || bus2.w_idx !== 7'(cnt) || bus2.w_data !== ref_w[cnt] ||
                bus2.w_last !== (cnt == 79) || busy2 !== 1'b1) begin
                fails++;
                $display("FAIL sha2_dis t=%0d: valid=%b idx=%0d data=%h last=%b busy=%b, required 1 %0d %h %b 1",
                         cnt, bus2.w_valid, bus2.w_idx, bus2.w_data, bus2.w_last, busy2,
                         cnt, ref_w[cnt], cnt == 79);
            end
            cap[cnt] = bus2.w_data;
            cnt++;
        end
        tests++;
        if (cap[16] !== 32'hC2C4C700) begin
            fails++;
            $display("FAIL sha2_dis_w16: W16=%h required c2c4c700", cap[16]);
        end
        @(negedge clk);
        tests++;
        if (bus2.w_valid !== 1'b0 || bus2.blk_ready !== 1'b1) begin
            fails++;
            $display("FAIL sha2_dis_end: valid=%b ready=%b required 0 1", bus2.w_valid, bus2.blk_ready);
        end
    endtask

    initial begin
        abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
        for (int i = 0; i < 16; i++) blk2[511-32*i -: 32] = 32'h9E3779B9 * (i + 1) ^ 32'h0F0F1234;
        bus.blk_valid = 1'b0;
        bus.blk_data = '0;
        bus.w_ready = 1'b1;
        bus2.blk_valid = 1'b0;
        bus2.blk_data = '0;
        bus2.w_ready = 1'b1;
        test_reset();
        test_sha1_abc();
        test_sha256_abc();
        test_back_pressure();
        test_abort();
        test_reset_mid();
        test_sha2_disabled();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
